// File: rtl/lipsi_pkg.sv
// Shared types and opcode constants for the LIPSI controller.
package lipsi_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    ALU,
    OPERAND,
    HALT
  } state_t;

  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [4:0] OP_IMM  = 5'b11000;
  localparam logic [7:0] OP_BR   = 8'hD0;
  localparam logic [7:0] OP_BRZ  = 8'hD2;
  localparam logic [7:0] OP_BRNZ = 8'hD3;
  localparam logic [7:0] OP_EXIT = 8'hFF;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_ADC,
    ALU_SBB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_LD
  } alu_op_t;

endpackage

// File: rtl/lipsi_decode.sv
// Combinational instruction-class decoder for the LIPSI ISA subset.
module lipsi_decode
  import lipsi_pkg::*;
(
  input  logic [7:0] i_instr,
  output logic       o_is_alu_reg,
  output logic       o_is_st,
  output logic       o_is_imm,
  output logic       o_is_br,
  output logic       o_is_brz,
  output logic       o_is_brnz,
  output logic       o_is_exit
);

  always_comb begin
    o_is_alu_reg = ~i_instr[7];
    o_is_st      = (i_instr[7:4] == OP_ST);
    o_is_imm     = (i_instr[7:3] == OP_IMM);
    o_is_br      = (i_instr == OP_BR);
    o_is_brz     = (i_instr == OP_BRZ);
    o_is_brnz    = (i_instr == OP_BRNZ);
    o_is_exit    = (i_instr == OP_EXIT);
  end

endmodule

// File: rtl/lipsi_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the LIPSI core.
module lipsi_ctrl
  import lipsi_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] dmem_addr,
  output logic              dmem_rd,
  output logic              dmem_wr,
  output logic [2:0]        alu_op,
  output logic              alu_src_imm,
  output logic              acc_load,
  input  logic              acc_zero,
  output logic              halted
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_halted;

  logic [7:0]        w_dec_in;
  logic              w_is_alu_reg;
  logic              w_is_st;
  logic              w_is_imm;
  logic              w_is_br;
  logic              w_is_brz;
  logic              w_is_brnz;
  logic              w_is_exit;
  logic              w_taken;
  logic [ADDR_W-1:0] w_pc_inc;
  alu_op_t           w_alu_op;

  // One decoder serves both phases: the fresh ROM byte in DECODE, the latched IR afterwards.
  assign w_dec_in = (r_state == DECODE) ? imem_data[7:0] : r_ir[7:0];

  lipsi_decode u_decode (
    .i_instr      (w_dec_in),
    .o_is_alu_reg (w_is_alu_reg),
    .o_is_st      (w_is_st),
    .o_is_imm     (w_is_imm),
    .o_is_br      (w_is_br),
    .o_is_brz     (w_is_brz),
    .o_is_brnz    (w_is_brnz),
    .o_is_exit    (w_is_exit)
  );

  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_taken  = w_is_br | (w_is_brz & acc_zero) | (w_is_brnz & ~acc_zero);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (run) begin
            r_pc    <= w_pc_inc;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          r_ir <= imem_data;
          if (w_is_alu_reg) begin
            r_state <= ALU;
          end else if (w_is_st) begin
            r_state <= FETCH;
          end else if (w_is_imm | w_is_br | w_is_brz | w_is_brnz) begin
            r_pc    <= w_pc_inc;
            r_state <= OPERAND;
          end else if (w_is_exit) begin
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else begin
            r_state <= FETCH;
          end
        end
        ALU: r_state <= FETCH;
        OPERAND: begin
          if (w_taken) r_pc <= ADDR_W'(imem_data);
          r_state <= FETCH;
        end
        HALT:    r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

  assign w_alu_op = alu_op_t'((r_state == OPERAND) ? r_ir[2:0] : r_ir[6:4]);

  always_comb begin
    imem_addr   = r_pc;
    dmem_addr   = {{(DATA_W-4){1'b0}}, w_dec_in[3:0]};
    dmem_rd     = 1'b0;
    dmem_wr     = 1'b0;
    acc_load    = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = w_alu_op;
    halted      = r_halted;
    case (r_state)
      DECODE: begin
        dmem_rd = w_is_alu_reg;
        dmem_wr = w_is_st;
      end
      ALU:     acc_load = 1'b1;
      OPERAND: begin
        acc_load    = w_is_imm;
        alu_src_imm = w_is_imm;
      end
      default: ;
    endcase
  end

endmodule
